// File: rtl/ysyx_22040365_lsu.sv
// Memory-access stage: issues one data-memory request per load/store, aligns and extends load
// data, and registers the stage-78 result bundle consumed by MEM/WB.
module ysyx_22040365_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic [63:0] in_wdata,
    input  logic        in_mem_rd,
    input  logic        in_mem_wr,
    input  logic [2:0]  in_funct3,
    input  logic        in_rd_en,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_inst,
    input  logic [63:0] in_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,
    output logic        valid_78,
    output logic [63:0] result_78,
    output logic        rd_en_78,
    output logic [4:0]  rd_addr_78,
    output logic [31:0] inst_78,
    output logic [63:0] pc_78,
    output logic        mis_78
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;
    logic   init_q;

    // Request holding registers
    logic [63:0] hold_addr_q;
    logic        hold_wen_q;
    logic [63:0] hold_wdata_q;
    logic [7:0]  hold_wmask_q;
    logic [2:0]  hold_funct3_q;
    logic        hold_rd_en_q;
    logic [4:0]  hold_rd_addr_q;
    logic [31:0] hold_inst_q;
    logic [63:0] hold_pc_q;

    // Output bundle registers
    logic        out_valid_q;
    logic [63:0] out_result_q;
    logic        out_rd_en_q;
    logic [4:0]  out_rd_addr_q;
    logic [31:0] out_inst_q;
    logic [63:0] out_pc_q;
    logic        out_mis_q;

    logic        accept;
    logic        is_mem;
    logic        illegal;
    logic        misalign;
    logic        fault;
    logic [2:0]  off_in;
    logic [7:0]  byte_mask;
    logic [7:0]  st_wmask;
    logic [63:0] st_wdata;
    logic [63:0] ld_shifted;
    logic [63:0] ld_data;

    logic        capture;
    logic        emit;
    logic        emit_from_hold;
    logic [63:0] emit_result;
    logic        emit_rd_en;
    logic        emit_mis;

    // in_ready stays low during reset and the first cycle after release.
    assign in_ready = (state_q == StIdle) && init_q;
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_mem_rd || in_mem_wr;
    assign off_in   = in_result[2:0];

    assign illegal  = (in_mem_rd && (in_funct3 == 3'b111)) || (in_mem_wr && in_funct3[2]);
    always_comb begin
        misalign = 1'b0;
        unique case (in_funct3[1:0])
            2'b00: misalign = 1'b0;
            2'b01: misalign = off_in[0];
            2'b10: misalign = |off_in[1:0];
            2'b11: misalign = |off_in;
            default: misalign = 1'b0;
        endcase
    end
    assign fault = is_mem && (illegal || misalign);

    always_comb begin
        byte_mask = 8'h00;
        unique case (in_funct3[1:0])
            2'b00: byte_mask = 8'h01;
            2'b01: byte_mask = 8'h03;
            2'b10: byte_mask = 8'h0F;
            2'b11: byte_mask = 8'hFF;
            default: byte_mask = 8'h00;
        endcase
    end
    assign st_wmask = byte_mask << off_in;
    assign st_wdata = in_wdata << {off_in, 3'b000};

    assign ld_shifted = mem_rsp_rdata >> {hold_addr_q[2:0], 3'b000};
    always_comb begin
        ld_data = ld_shifted;
        case (hold_funct3_q)
            3'b000: ld_data = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001: ld_data = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b010: ld_data = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            3'b011: ld_data = ld_shifted;
            3'b100: ld_data = {56'b0, ld_shifted[7:0]};
            3'b101: ld_data = {48'b0, ld_shifted[15:0]};
            3'b110: ld_data = {32'b0, ld_shifted[31:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && is_mem && !fault) state_d = StReq;
            StReq:  if (mem_req_ready) state_d = hold_wen_q ? StIdle : StWait;
            StWait: if (mem_rsp_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture        = 1'b0;
        emit           = 1'b0;
        emit_from_hold = 1'b0;
        emit_result    = in_result;
        emit_rd_en     = 1'b0;
        emit_mis       = 1'b0;
        mem_req_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!is_mem) begin
                        emit       = 1'b1;
                        emit_rd_en = in_rd_en;
                    end else if (fault) begin
                        emit     = 1'b1;
                        emit_mis = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready && hold_wen_q) begin
                    emit           = 1'b1;
                    emit_from_hold = 1'b1;
                    emit_result    = hold_addr_q;
                end
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    emit           = 1'b1;
                    emit_from_hold = 1'b1;
                    emit_result    = ld_data;
                    emit_rd_en     = hold_rd_en_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_addr_q    <= '0;
            hold_wen_q     <= 1'b0;
            hold_wdata_q   <= '0;
            hold_wmask_q   <= '0;
            hold_funct3_q  <= '0;
            hold_rd_en_q   <= 1'b0;
            hold_rd_addr_q <= '0;
            hold_inst_q    <= '0;
            hold_pc_q      <= '0;
        end else if (capture) begin
            hold_addr_q    <= in_result;
            hold_wen_q     <= in_mem_wr;
            hold_wdata_q   <= in_mem_wr ? st_wdata : 64'b0;
            hold_wmask_q   <= in_mem_wr ? st_wmask : 8'b0;
            hold_funct3_q  <= in_funct3;
            hold_rd_en_q   <= in_rd_en && in_mem_rd;
            hold_rd_addr_q <= in_rd_addr;
            hold_inst_q    <= in_inst;
            hold_pc_q      <= in_pc;
        end
    end

    assign mem_req_addr  = {hold_addr_q[63:3], 3'b000};
    assign mem_req_wen   = hold_wen_q;
    assign mem_req_wdata = hold_wdata_q;
    assign mem_req_wmask = hold_wmask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_en_q   <= 1'b0;
            out_rd_addr_q <= '0;
            out_inst_q    <= '0;
            out_pc_q      <= '0;
            out_mis_q     <= 1'b0;
        end else begin
            out_valid_q <= emit;
            if (emit) begin
                out_result_q  <= emit_result;
                out_rd_en_q   <= emit_rd_en;
                out_mis_q     <= emit_mis;
                out_rd_addr_q <= emit_from_hold ? hold_rd_addr_q : in_rd_addr;
                out_inst_q    <= emit_from_hold ? hold_inst_q : in_inst;
                out_pc_q      <= emit_from_hold ? hold_pc_q : in_pc;
            end
        end
    end

    assign valid_78   = out_valid_q;
    assign result_78  = out_result_q;
    assign rd_en_78   = out_valid_q && out_rd_en_q;
    assign rd_addr_78 = out_rd_addr_q;
    assign inst_78    = out_inst_q;
    assign pc_78      = out_pc_q;
    assign mis_78     = out_mis_q;

endmodule

// File: tb/tb_ysyx_22040365_lsu.sv
// Scoreboard bench for ysyx_22040365_lsu: stimulus pushes expected bundles/requests, monitors
// pop and compare whenever the DUT presents valid_78 or mem_req_valid.
module tb_ysyx_22040365_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [63:0] in_wdata;
    logic        in_mem_rd;
    logic        in_mem_wr;
    logic [2:0]  in_funct3;
    logic        in_rd_en;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        valid_78;
    logic [63:0] result_78;
    logic        rd_en_78;
    logic [4:0]  rd_addr_78;
    logic [31:0] inst_78;
    logic [63:0] pc_78;
    logic        mis_78;

    ysyx_22040365_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_wdata      (in_wdata),
        .in_mem_rd     (in_mem_rd),
        .in_mem_wr     (in_mem_wr),
        .in_funct3     (in_funct3),
        .in_rd_en      (in_rd_en),
        .in_rd_addr    (in_rd_addr),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .valid_78      (valid_78),
        .result_78     (result_78),
        .rd_en_78      (rd_en_78),
        .rd_addr_78    (rd_addr_78),
        .inst_78       (inst_78),
        .pc_78         (pc_78),
        .mis_78        (mis_78)
    );

    typedef struct {
        logic [63:0] result;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic [31:0] inst;
        logic [63:0] pc;
        logic        mis;
    } bundle_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        chk_data;
    } req_t;

    bundle_t sb[$];
    req_t    rq[$];
    bundle_t eb;
    req_t    er;

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_bundle(input logic [63:0] res, input logic rde, input logic [4:0] rda,
                              input logic [31:0] inst, input logic [63:0] pc, input logic mis);
        bundle_t b;
        b.result = res; b.rd_en = rde; b.rd_addr = rda; b.inst = inst; b.pc = pc; b.mis = mis;
        sb.push_back(b);
    endtask

    task automatic exp_req(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                           input logic [7:0] wmask, input logic chk_data);
        req_t r;
        r.addr = addr; r.wen = wen; r.wdata = wdata; r.wmask = wmask; r.chk_data = chk_data;
        rq.push_back(r);
    endtask

    // Presents one instruction and returns #1 after the accepting edge.
    task automatic send(input logic [63:0] res, input logic [63:0] wd, input logic rd,
                        input logic wr, input logic [2:0] f3, input logic rde,
                        input logic [4:0] rda, input logic [31:0] inst, input logic [63:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", in_ready, 1'b1);
        in_result = res; in_wdata = wd; in_mem_rd = rd; in_mem_wr = wr; in_funct3 = f3;
        in_rd_en = rde; in_rd_addr = rda; in_inst = inst; in_pc = pc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after send() of a load with mem_req_ready=1.
    task automatic load_rsp(input int delay, input logic [63:0] data);
        @(posedge clk);
        #1;
        repeat (delay) begin
            @(negedge clk);
            chk("ld_wait_no_valid", valid_78, 1'b0);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = data;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        @(negedge clk);
        chk("ld_valid_after_rsp", valid_78, 1'b1);
    endtask

    // Bundle and request monitors
    always @(negedge clk) begin
        if (rst) begin
            if (valid_78) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid_78", valid_78, 1'b0);
                end else begin
                    eb = sb.pop_front();
                    chk("result_78", result_78, eb.result);
                    chk("rd_en_78", rd_en_78, eb.rd_en);
                    chk("rd_addr_78", rd_addr_78, eb.rd_addr);
                    chk("inst_78", inst_78, eb.inst);
                    chk("pc_78", pc_78, eb.pc);
                    chk("mis_78", mis_78, eb.mis);
                end
            end else begin
                chk("rd_en_78_idle", rd_en_78, 1'b0);
            end
            if (mem_req_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_mem_req_valid", mem_req_valid, 1'b0);
                end else begin
                    er = rq[0];
                    chk("mem_req_addr", mem_req_addr, er.addr);
                    chk("mem_req_wen", mem_req_wen, er.wen);
                    if (er.chk_data) begin
                        chk("mem_req_wdata", mem_req_wdata, er.wdata);
                        chk("mem_req_wmask", mem_req_wmask, er.wmask);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst && mem_req_valid && mem_req_ready && rq.size() > 0) rq.delete(0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_result = '0; in_wdata = '0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
        in_funct3 = '0; in_rd_en = 1'b0; in_rd_addr = '0; in_inst = '0; in_pc = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, 64'h0);
        chk("rst_valid_78", valid_78, 1'b0);
        chk("rst_result_78", result_78, 64'h0);
        chk("rst_mis_78", mis_78, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("in_ready_first_cycle", in_ready, 1'b0);
        @(posedge clk);
        #1 chk("in_ready_after_release", in_ready, 1'b1);

        // ADD
        exp_bundle(64'h1234, 1'b1, 5'd5, 32'h0000_0033, 64'h8000_0000, 1'b0);
        send(64'h1234, 64'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h0000_0033, 64'h8000_0000);
        @(negedge clk);
        chk("add_latency", valid_78, 1'b1);

        // LB / LBU at offset 3, byte 0x80
        exp_req(64'h8000_0000, 1'b0, 64'h0, 8'h0, 1'b0);
        exp_bundle(64'hFFFF_FFFF_FFFF_FF80, 1'b1, 5'd6, 32'h0030_0303, 64'h8000_0004, 1'b0);
        send(64'h8000_0003, 64'h0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd6, 32'h0030_0303, 64'h8000_0004);
        load_rsp(0, 64'h0000_0000_8000_0000);
        exp_req(64'h8000_0000, 1'b0, 64'h0, 8'h0, 1'b0);
        exp_bundle(64'h0000_0000_0000_0080, 1'b1, 5'd6, 32'h0030_4303, 64'h8000_0008, 1'b0);
        send(64'h8000_0003, 64'h0, 1'b1, 1'b0, 3'b100, 1'b1, 5'd6, 32'h0030_4303, 64'h8000_0008);
        load_rsp(0, 64'h0000_0000_8000_0000);

        // LW / LWU at offset 4
        exp_req(64'h8000_0000, 1'b0, 64'h0, 8'h0, 1'b0);
        exp_bundle(64'hFFFF_FFFF_8765_4321, 1'b1, 5'd7, 32'h0040_2383, 64'h8000_000C, 1'b0);
        send(64'h8000_0004, 64'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0040_2383, 64'h8000_000C);
        load_rsp(1, 64'h8765_4321_0000_0000);
        exp_req(64'h8000_0000, 1'b0, 64'h0, 8'h0, 1'b0);
        exp_bundle(64'h0000_0000_8765_4321, 1'b1, 5'd7, 32'h0040_6383, 64'h8000_0010, 1'b0);
        send(64'h8000_0004, 64'h0, 1'b1, 1'b0, 3'b110, 1'b1, 5'd7, 32'h0040_6383, 64'h8000_0010);
        load_rsp(0, 64'h8765_4321_0000_0000);

        // SH at offset 6 with ready held low for 3 cycles
        mem_req_ready = 1'b0;
        exp_req(64'h8000_0000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 1'b1);
        exp_bundle(64'h8000_0006, 1'b0, 5'd3, 32'h00A5_1323, 64'h8000_0014, 1'b0);
        send(64'h8000_0006, 64'h0000_0000_0000_ABCD, 1'b0, 1'b1, 3'b001, 1'b1, 5'd3,
             32'h00A5_1323, 64'h8000_0014);
        repeat (3) begin
            @(negedge clk);
            chk("sh_req_held", mem_req_valid, 1'b1);
            chk("sh_in_ready_low", in_ready, 1'b0);
            chk("sh_no_valid", valid_78, 1'b0);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("sh_valid_after_hs", valid_78, 1'b1);
        chk("sh_in_ready_back", in_ready, 1'b1);

        // SD with ready already high: +2
        exp_req(64'h8000_0018, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1);
        exp_bundle(64'h8000_0018, 1'b0, 5'd0, 32'h00B5_3C23, 64'h8000_0018, 1'b0);
        send(64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 3'b011, 1'b0, 5'd0,
             32'h00B5_3C23, 64'h8000_0018);
        @(negedge clk);
        chk("sd_req_plus1", mem_req_valid, 1'b1);
        chk("sd_no_valid_plus1", valid_78, 1'b0);
        @(negedge clk);
        chk("sd_valid_plus2", valid_78, 1'b1);

        // SW at offset 4
        exp_req(64'h8000_0020, 1'b1, 64'h5566_7788_0000_0000, 8'hF0, 1'b1);
        exp_bundle(64'h8000_0024, 1'b0, 5'd0, 32'h00C5_2223, 64'h8000_001C, 1'b0);
        send(64'h8000_0024, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0,
             32'h00C5_2223, 64'h8000_001C);
        @(negedge clk);
        @(negedge clk);
        chk("sw_valid", valid_78, 1'b1);

        // Misaligned LW, illegal SB-encoding-100 store, illegal load 111
        exp_bundle(64'h8000_0002, 1'b0, 5'd8, 32'h0020_2403, 64'h8000_0020, 1'b1);
        send(64'h8000_0002, 64'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd8, 32'h0020_2403, 64'h8000_0020);
        @(negedge clk);
        chk("mis_lw_no_req", mem_req_valid, 1'b0);
        chk("mis_lw_valid", valid_78, 1'b1);
        exp_bundle(64'h8000_0008, 1'b0, 5'd1, 32'h00D5_4423, 64'h8000_0024, 1'b1);
        send(64'h8000_0008, 64'h55, 1'b0, 1'b1, 3'b100, 1'b0, 5'd1, 32'h00D5_4423, 64'h8000_0024);
        @(negedge clk);
        chk("ill_st_no_req", mem_req_valid, 1'b0);
        exp_bundle(64'h8000_0000, 1'b0, 5'd2, 32'h0000_7103, 64'h8000_0028, 1'b1);
        send(64'h8000_0000, 64'h0, 1'b1, 1'b0, 3'b111, 1'b1, 5'd2, 32'h0000_7103, 64'h8000_0028);
        @(negedge clk);
        chk("ill_ld_no_req", mem_req_valid, 1'b0);

        // LD with 4-cycle response delay
        exp_req(64'h8000_0010, 1'b0, 64'h0, 8'h0, 1'b0);
        exp_bundle(64'h0123_4567_89AB_CDEF, 1'b1, 5'd10, 32'h0100_3503, 64'h8000_002C, 1'b0);
        send(64'h8000_0010, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1, 5'd10, 32'h0100_3503, 64'h8000_002C);
        load_rsp(4, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        chk("ld_single_pulse", valid_78, 1'b0);

        // Spurious response in IDLE
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("spurious_no_valid", valid_78, 1'b0);
        chk("spurious_in_ready", in_ready, 1'b1);

        // Reset while in WAIT
        exp_req(64'h8000_0020, 1'b0, 64'h0, 8'h0, 1'b0);
        send(64'h8000_0020, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1, 5'd9, 32'h0200_3483, 64'h8000_0030);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("wrst_in_ready", in_ready, 1'b0);
        chk("wrst_req_valid", mem_req_valid, 1'b0);
        chk("wrst_req_addr", mem_req_addr, 64'h0);
        chk("wrst_req_wen", mem_req_wen, 1'b0);
        chk("wrst_req_wdata", mem_req_wdata, 64'h0);
        chk("wrst_req_wmask", mem_req_wmask, 8'h0);
        chk("wrst_valid_78", valid_78, 1'b0);
        chk("wrst_result_78", result_78, 64'h0);
        chk("wrst_rd_en_78", rd_en_78, 1'b0);
        chk("wrst_rd_addr_78", rd_addr_78, 5'd0);
        chk("wrst_inst_78", inst_78, 32'h0);
        chk("wrst_pc_78", pc_78, 64'h0);
        chk("wrst_mis_78", mis_78, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("wrst_in_ready_first", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("wrst_in_ready_idle", in_ready, 1'b1);
        @(negedge clk);
        chk("wrst_no_pulse", valid_78, 1'b0);

        exp_bundle(64'h0000_0000_0000_0042, 1'b1, 5'd11, 32'h0420_0593, 64'h8000_0034, 1'b0);
        send(64'h42, 64'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd11, 32'h0420_0593, 64'h8000_0034);
        @(negedge clk);
        chk("post_rst_add_latency", valid_78, 1'b1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
